alu_bank_array: RTL and testbench

Parametrised multi-bank ALU. It is the next generation of the fixed 4-bank, 32-bit ALU. It adds configurable bank count, data width and per-operation latency, plus valid/ready handshakes on both input and output so a bank can be back-pressured. Each bank runs independently with its own FSM and sits between the command sources and the scoreboard/response consumer.

---
 rtl/alu_bank_array.sv | 190 +++++++++++++++++++
 tb/tb_alu_bank_array.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bank_array.sv
// alu_bank_array: NUM_BANKS independent ALU lanes (ADD / MULTIPLY / AND).
// Each lane has a valid/ready handshake on both sides and a programmable
// latency per operation. Lanes share only clock and reset.

module alu_bank_lane #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADD_LATENCY = 3,
    parameter int MUL_LATENCY = 5,
    parameter int AND_LATENCY = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_command,
    input  logic [DATA_WIDTH-1:0] in_data1,
    input  logic [DATA_WIDTH-1:0] in_data2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_response,
    output logic [DATA_WIDTH-1:0] out_data
);
    typedef enum logic [1:0] {CMD_NOP, CMD_ADD, CMD_MUL, CMD_AND} cmd_e;
    typedef enum logic [1:0] {IDLE, EXECUTE, RESPOND} state_e;

    typedef struct packed {
        cmd_e                  cmd;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
    } req_t;

    localparam logic [1:0] RSP_NONE = 2'b00;
    localparam logic [1:0] RSP_OK   = 2'b01;
    localparam logic [1:0] RSP_OVF  = 2'b10;

    // Counter preloads: latency L gives out_valid exactly L edges after accept.
    localparam logic [3:0] ADD_CNT = 4'(ADD_LATENCY - 1);
    localparam logic [3:0] MUL_CNT = 4'(MUL_LATENCY - 1);
    localparam logic [3:0] AND_CNT = 4'(AND_LATENCY - 1);

    state_e                    state, state_nxt;
    req_t                      req_q;
    logic [3:0]                cnt;
    logic [3:0]                lat_m1;
    logic                      accept;
    logic [DATA_WIDTH:0]       sum;
    logic [2*DATA_WIDTH-1:0]   prod;
    logic [DATA_WIDTH-1:0]     res_data;
    logic [1:0]                res_resp;

    // NOP is consumed in IDLE without leaving the state.
    assign accept = (state == IDLE) && in_valid && (in_command != CMD_NOP);

    // Select the counter preload for the incoming command.
    always_comb begin
        lat_m1 = ADD_CNT;
        case (in_command)
            CMD_MUL: lat_m1 = MUL_CNT;
            CMD_AND: lat_m1 = AND_CNT;
            default: lat_m1 = ADD_CNT;
        endcase
    end

    assign sum  = {1'b0, req_q.a} + {1'b0, req_q.b};
    assign prod = {{DATA_WIDTH{1'b0}}, req_q.a} * {{DATA_WIDTH{1'b0}}, req_q.b};

    // Result and status from the registered operands only.
    always_comb begin
        res_data = '0;
        res_resp = RSP_OK;
        case (req_q.cmd)
            CMD_ADD: begin
                res_data = sum[DATA_WIDTH-1:0];
                res_resp = sum[DATA_WIDTH] ? RSP_OVF : RSP_OK;
            end
            CMD_MUL: begin
                res_data = prod[DATA_WIDTH-1:0];
                res_resp = (prod[2*DATA_WIDTH-1:DATA_WIDTH] != '0) ? RSP_OVF : RSP_OK;
            end
            CMD_AND: res_data = req_q.a & req_q.b;
            default: res_data = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state and handshake outputs; in_ready held low under reset.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = reset;
                if (accept) state_nxt = EXECUTE;
            end
            EXECUTE: if (cnt == 4'd0) state_nxt = RESPOND;
            RESPOND: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, latency countdown and result/response registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_q        <= '0;
            cnt          <= '0;
            out_data     <= '0;
            out_response <= RSP_NONE;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    req_q <= '{cmd: cmd_e'(in_command), a: in_data1, b: in_data2};
                    cnt   <= lat_m1;
                end
                EXECUTE: begin
                    if (cnt == 4'd0) begin
                        out_data     <= res_data;
                        out_response <= res_resp;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                // out_data keeps its last value after the transfer.
                RESPOND: if (out_ready) out_response <= RSP_NONE;
                default: ;
            endcase
        end
    end
endmodule

module alu_bank_array #(
    parameter int NUM_BANKS   = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ADD_LATENCY = 3,
    parameter int MUL_LATENCY = 5,
    parameter int AND_LATENCY = 3
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUM_BANKS-1:0]                 in_valid,
    output logic [NUM_BANKS-1:0]                 in_ready,
    input  logic [NUM_BANKS-1:0][1:0]            in_command,
    input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] in_data1,
    input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] in_data2,
    output logic [NUM_BANKS-1:0]                 out_valid,
    input  logic [NUM_BANKS-1:0]                 out_ready,
    output logic [NUM_BANKS-1:0][1:0]            out_response,
    output logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] out_data
);
    if (NUM_BANKS < 1 || NUM_BANKS > 16) begin : g_bad_banks
        $error("alu_bank_array: NUM_BANKS must be 1..16");
    end
    if (DATA_WIDTH < 8 || DATA_WIDTH > 64) begin : g_bad_width
        $error("alu_bank_array: DATA_WIDTH must be 8..64");
    end
    if (ADD_LATENCY < 1 || ADD_LATENCY > 15 ||
        MUL_LATENCY < 1 || MUL_LATENCY > 15 ||
        AND_LATENCY < 1 || AND_LATENCY > 15) begin : g_bad_lat
        $error("alu_bank_array: latencies must be 1..15");
    end

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        alu_bank_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADD_LATENCY(ADD_LATENCY),
            .MUL_LATENCY(MUL_LATENCY),
            .AND_LATENCY(AND_LATENCY)
        ) u_lane (
            .clock       (clock),
            .reset       (reset),
            .in_valid    (in_valid[k]),
            .in_ready    (in_ready[k]),
            .in_command  (in_command[k]),
            .in_data1    (in_data1[k]),
            .in_data2    (in_data2[k]),
            .out_valid   (out_valid[k]),
            .out_ready   (out_ready[k]),
            .out_response(out_response[k]),
            .out_data    (out_data[k])
        );
    end
endmodule

// File: tb/tb_alu_bank_array.sv
// Directed bench for alu_bank_array: 4x32 instance plus a 1x8 instance.
// Inputs change and outputs are sampled on the falling edge.

module tb_alu_bank_array;
    localparam int NB = 4;
    localparam int DW = 32;
    localparam logic [1:0] C_NOP = 2'd0, C_ADD = 2'd1, C_MUL = 2'd2, C_AND = 2'd3;

    logic clock = 1'b0;
    logic reset;
    logic [NB-1:0]         in_valid, in_ready, out_valid, out_ready;
    logic [NB-1:0][1:0]    in_command, out_response;
    logic [NB-1:0][DW-1:0] in_data1, in_data2, out_data;

    logic [0:0]      v8, r8, ov8, ordy8;
    logic [0:0][1:0] cmd8, rsp8;
    logic [0:0][7:0] a8, b8, d8;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    alu_bank_array #(.NUM_BANKS(NB), .DATA_WIDTH(DW)) u_dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_command(in_command),
        .in_data1(in_data1), .in_data2(in_data2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_response(out_response), .out_data(out_data)
    );

    alu_bank_array #(.NUM_BANKS(1), .DATA_WIDTH(8)) u_dut8 (
        .clock(clock), .reset(reset),
        .in_valid(v8), .in_ready(r8), .in_command(cmd8),
        .in_data1(a8), .in_data2(b8),
        .out_valid(ov8), .out_ready(ordy8),
        .out_response(rsp8), .out_data(d8)
    );

    // Present one command at the current falling edge; returns just after the accept edge.
    task automatic issue(input int b, input logic [1:0] c, input logic [DW-1:0] x, input logic [DW-1:0] y);
        in_valid[b] = 1'b1; in_command[b] = c; in_data1[b] = x; in_data2[b] = y;
        @(negedge clock);
        in_valid[b] = 1'b0;
    endtask

    // Falling edges until out_valid[b]; bounded, a timeout returns 30.
    task automatic wait_valid(input int b, output int n);
        n = 0;
        while (n < 30 && out_valid[b] !== 1'b1) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        logic saw;
        out_ready = '1;
        // Leave a nonzero result on bank 2 so the reset clear is visible.
        issue(2, C_AND, 32'hFF, 32'hFF);
        wait_valid(2, n);
        @(negedge clock);
        issue(2, C_MUL, 32'd5, 32'd7);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL reset_out_valid: got %h expected 0", out_valid); end
        checks++; if (out_response !== 8'h00) begin errors++; $display("FAIL reset_out_response: got %h expected 00", out_response); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL reset_in_ready: got %h expected 0", in_ready); end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (in_ready !== 4'hF) begin errors++; $display("FAIL reset_release_in_ready: got %h expected f", in_ready); end
        saw = 1'b0;
        repeat (10) begin
            @(negedge clock);
            if (out_valid[2] !== 1'b0) saw = 1'b1;
        end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL reset_no_bank2_resp: got %b expected 0", saw); end
    endtask

    task automatic test_add();
        int n;
        issue(0, C_ADD, 32'hFFFF_FFFF, 32'h1);
        wait_valid(0, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL add_latency: got %0d expected 3", n); end
        checks++; if (out_data[0] !== 32'h0) begin errors++; $display("FAIL add_ovf_data: got %h expected 00000000", out_data[0]); end
        checks++; if (out_response[0] !== 2'b10) begin errors++; $display("FAIL add_ovf_resp: got %b expected 10", out_response[0]); end
        @(negedge clock);
        checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL add_valid_drop: got %b expected 0", out_valid[0]); end
        checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL add_ready_back: got %b expected 1", in_ready[0]); end
        issue(0, C_ADD, 32'h10, 32'h20);
        wait_valid(0, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL add2_latency: got %0d expected 3", n); end
        checks++; if (out_data[0] !== 32'h30) begin errors++; $display("FAIL add_data: got %h expected 00000030", out_data[0]); end
        checks++; if (out_response[0] !== 2'b01) begin errors++; $display("FAIL add_resp: got %b expected 01", out_response[0]); end
        @(negedge clock);
    endtask

    task automatic test_mul();
        int n;
        issue(1, C_MUL, 32'h0001_0000, 32'h0001_0000);
        wait_valid(1, n);
        checks++; if (n !== 5) begin errors++; $display("FAIL mul_latency: got %0d expected 5", n); end
        checks++; if (out_data[1] !== 32'h0) begin errors++; $display("FAIL mul_ovf_data: got %h expected 00000000", out_data[1]); end
        checks++; if (out_response[1] !== 2'b10) begin errors++; $display("FAIL mul_ovf_resp: got %b expected 10", out_response[1]); end
        @(negedge clock);
        issue(1, C_MUL, 32'h1234, 32'h10);
        wait_valid(1, n);
        checks++; if (out_data[1] !== 32'h0001_2340) begin errors++; $display("FAIL mul_data: got %h expected 00012340", out_data[1]); end
        checks++; if (out_response[1] !== 2'b01) begin errors++; $display("FAIL mul_resp: got %b expected 01", out_response[1]); end
        @(negedge clock);
    endtask

    task automatic test_and_hold();
        int n;
        issue(3, C_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        // Disturb inputs while the lane is executing.
        in_valid[3] = 1'b1; in_data1[3] = '0; in_command[3] = C_ADD;
        @(negedge clock);
        in_valid[3] = 1'b0;
        wait_valid(3, n);
        checks++; if (n + 1 !== 3) begin errors++; $display("FAIL and_latency: got %0d expected 3", n + 1); end
        checks++; if (out_data[3] !== 32'hF000_F000) begin errors++; $display("FAIL and_data: got %h expected f000f000", out_data[3]); end
        checks++; if (out_response[3] !== 2'b01) begin errors++; $display("FAIL and_resp: got %b expected 01", out_response[3]); end
        @(negedge clock);
    endtask

    task automatic test_backpressure();
        int n;
        out_ready[0] = 1'b0;
        issue(0, C_ADD, 32'd5, 32'd6);
        wait_valid(0, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL bp_latency: got %0d expected 3", n); end
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = 1'b1; in_command[0] = C_ADD; in_data1[0] = 32'd1; in_data2[0] = 32'd1;
            @(negedge clock);
            checks++; if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_valid_hold[%0d]: got %b expected 1", i, out_valid[0]); end
            checks++; if (out_data[0] !== 32'hB) begin errors++; $display("FAIL bp_data_hold[%0d]: got %h expected 0000000b", i, out_data[0]); end
            checks++; if (out_response[0] !== 2'b01) begin errors++; $display("FAIL bp_resp_hold[%0d]: got %b expected 01", i, out_response[0]); end
            checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready[0]); end
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clock);
        checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", out_valid[0]); end
        checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready[0]); end
        checks++; if (out_response[0] !== 2'b00) begin errors++; $display("FAIL bp_release_resp: got %b expected 00", out_response[0]); end
        checks++; if (out_data[0] !== 32'hB) begin errors++; $display("FAIL bp_release_data: got %h expected 0000000b", out_data[0]); end
        n = 0;
        repeat (6) begin
            @(negedge clock);
            if (out_valid[0] !== 1'b0) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL bp_ignored_cmd: got %0d valid cycles expected 0", n); end
    endtask

    task automatic test_back_to_back();
        int first [NB];
        logic [DW-1:0] dat [NB];
        logic [1:0] rsp [NB];
        int rdy_bad, v2;
        for (int b = 0; b < NB; b++) begin first[b] = 0; dat[b] = '0; rsp[b] = '0; end
        rdy_bad = 0; v2 = 0;
        in_valid = 4'hF;
        in_command[0] = C_ADD; in_data1[0] = 32'd1;  in_data2[0] = 32'd2;
        in_command[1] = C_MUL; in_data1[1] = 32'd3;  in_data2[1] = 32'd4;
        in_command[2] = C_NOP; in_data1[2] = 32'd9;  in_data2[2] = 32'd9;
        in_command[3] = C_AND; in_data1[3] = 32'hFF; in_data2[3] = 32'h0F;
        @(negedge clock);
        in_valid = '0;
        if (in_ready[2] !== 1'b1) rdy_bad++;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (in_ready[2] !== 1'b1) rdy_bad++;
            if (out_valid[2] !== 1'b0) v2++;
            for (int b = 0; b < NB; b++)
                if (out_valid[b] === 1'b1 && first[b] == 0) begin
                    first[b] = c; dat[b] = out_data[b]; rsp[b] = out_response[b];
                end
        end
        checks++; if (first[0] !== 3) begin errors++; $display("FAIL b2b_lat0: got %0d expected 3", first[0]); end
        checks++; if (first[1] !== 5) begin errors++; $display("FAIL b2b_lat1: got %0d expected 5", first[1]); end
        checks++; if (first[3] !== 3) begin errors++; $display("FAIL b2b_lat3: got %0d expected 3", first[3]); end
        checks++; if (dat[0] !== 32'h3) begin errors++; $display("FAIL b2b_data0: got %h expected 00000003", dat[0]); end
        checks++; if (dat[1] !== 32'hC) begin errors++; $display("FAIL b2b_data1: got %h expected 0000000c", dat[1]); end
        checks++; if (dat[3] !== 32'hF) begin errors++; $display("FAIL b2b_data3: got %h expected 0000000f", dat[3]); end
        checks++; if (rsp[0] !== 2'b01 || rsp[1] !== 2'b01 || rsp[3] !== 2'b01) begin
            errors++; $display("FAIL b2b_resp: got %b %b %b expected 01 01 01", rsp[0], rsp[1], rsp[3]);
        end
        checks++; if (v2 !== 0) begin errors++; $display("FAIL b2b_nop_valid: got %0d cycles expected 0", v2); end
        checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL b2b_nop_ready: got %0d low cycles expected 0", rdy_bad); end
    endtask

    task automatic test_width8();
        int n;
        logic [1:0] c8 [3];
        logic [7:0] x8 [3], y8 [3], ed [3];
        logic [1:0] er [3];
        c8[0] = C_ADD; x8[0] = 8'hFF; y8[0] = 8'h01; ed[0] = 8'h00; er[0] = 2'b10;
        c8[1] = C_MUL; x8[1] = 8'h10; y8[1] = 8'h10; ed[1] = 8'h00; er[1] = 2'b10;
        c8[2] = C_MUL; x8[2] = 8'h0F; y8[2] = 8'h11; ed[2] = 8'hFF; er[2] = 2'b01;
        ordy8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v8 = 1'b1; cmd8[0] = c8[i]; a8[0] = x8[i]; b8[0] = y8[i];
            @(negedge clock);
            v8 = 1'b0;
            n = 0;
            while (n < 30 && ov8[0] !== 1'b1) begin @(negedge clock); n++; end
            checks++; if (n !== ((i == 0) ? 3 : 5)) begin errors++; $display("FAIL w8_latency[%0d]: got %0d", i, n); end
            checks++; if (d8[0] !== ed[i]) begin errors++; $display("FAIL w8_data[%0d]: got %h expected %h", i, d8[0], ed[i]); end
            checks++; if (rsp8[0] !== er[i]) begin errors++; $display("FAIL w8_resp[%0d]: got %b expected %b", i, rsp8[0], er[i]); end
            @(negedge clock);
        end
    endtask

    initial begin
        reset = 1'b0;
        in_valid = '0; in_command = '0; in_data1 = '0; in_data2 = '0; out_ready = '1;
        v8 = '0; cmd8 = '0; a8 = '0; b8 = '0; ordy8 = '1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        test_reset();
        test_add();
        test_mul();
        test_and_hold();
        test_backpressure();
        test_back_to_back();
        test_width8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
